// File: rtl/seven_segment_scan_controller_if.sv
// Load handshake between the processor output port and the seven-segment controller.
// The master presents a binary value; the controller raises loadReady while idle.
interface seven_segment_scan_controller_if #(
   parameter int WIDTH = 13
);
   logic             loadValid;
   logic             loadReady;
   logic [WIDTH-1:0] value;

   modport master (
      output loadValid,
      output value,
      input  loadReady
   );

   modport slave (
      input  loadValid,
      input  value,
      output loadReady
   );
endinterface

// File: rtl/seven_segment_scan_controller.sv
// Binary-to-BCD (double-dabble) front end for the multiplexed seven-segment display.
// The result is held in display registers and scanned onto one shared digit decoder.
module seven_segment_scan_controller #(
   parameter int DIGITS   = 4,
   parameter int WIDTH    = 13,
   parameter int SCAN_DIV = 1000
) (
   input  logic                                  clock,
   input  logic                                  resetN,
   seven_segment_scan_controller_if.slave        loadBus,
   output logic [3:0]                            digitNumber,
   output logic [DIGITS-1:0]                     digitSelect,
   output logic                                  overflow
);

   localparam int BCD_W  = 4 * DIGITS;
   localparam int ITER_W = $clog2(WIDTH + 1);
   localparam int PRE_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [63:0] MAX_VALUE = 64'(10 ** DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      COMMIT  = 2'd2
   } state_t;

   state_t                   r_state;
   state_t                   w_nextState;
   logic                     w_loadReady;
   logic                     w_accept;

   logic [WIDTH-1:0]         r_shift;
   logic [BCD_W-1:0]         r_bcd;
   logic [BCD_W-1:0]         w_adjusted;
   logic [ITER_W-1:0]        r_iter;
   logic                     r_ovfPending;
   logic [63:0]              w_valueWide;

   logic [DIGITS-1:0][3:0]   r_display;
   logic [DIGITS-1:0][3:0]   w_blanked;
   logic                     w_seen;
   logic                     r_overflow;

   logic [PRE_W-1:0]         r_prescale;
   logic [IDX_W-1:0]         r_index;

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_loadReady = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         IDLE: begin
            w_loadReady = 1'b1;
            if (loadBus.loadValid) begin
               w_accept    = 1'b1;
               w_nextState = CONVERT;
            end
         end
         CONVERT: begin
            if (r_iter == ITER_W'(WIDTH - 1)) begin
               w_nextState = COMMIT;
            end
         end
         COMMIT: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   assign loadBus.loadReady = w_loadReady;
   assign w_valueWide       = 64'(loadBus.value);

   // Add-3 stays inside each nibble; a digit never carries into its neighbour here.
   always_comb begin
      w_adjusted = r_bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5) begin
            w_adjusted[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
         end
      end
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_shift      <= '0;
         r_bcd        <= '0;
         r_iter       <= '0;
         r_ovfPending <= 1'b0;
         r_display    <= '0;
         r_overflow   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_shift      <= loadBus.value;
                  r_bcd        <= '0;
                  r_iter       <= '0;
                  r_ovfPending <= (w_valueWide > MAX_VALUE);
               end
            end
            CONVERT: begin
               r_bcd   <= {w_adjusted[BCD_W-2:0], r_shift[WIDTH-1]};
               r_shift <= {r_shift[WIDTH-2:0], 1'b0};
               r_iter  <= r_iter + 1'b1;
            end
            COMMIT: begin
               if (r_ovfPending) begin
                  r_display  <= '1;
                  r_overflow <= 1'b1;
               end else begin
                  r_display  <= r_bcd;
                  r_overflow <= 1'b0;
               end
            end
            default: begin
               r_iter <= '0;
            end
         endcase
      end
   end

   // Scan timing is free-running so the display never stalls while a value converts.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_prescale <= '0;
         r_index    <= '0;
      end else if (r_prescale == PRE_W'(SCAN_DIV - 1)) begin
         r_prescale <= '0;
         if (r_index == IDX_W'(DIGITS - 1)) begin
            r_index <= '0;
         end else begin
            r_index <= r_index + 1'b1;
         end
      end else begin
         r_prescale <= r_prescale + 1'b1;
      end
   end

   always_comb begin
      w_seen    = 1'b0;
      w_blanked = r_display;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if (r_display[i] != 4'd0) begin
            w_seen = 1'b1;
         end
         if (!w_seen) begin
            w_blanked[i] = 4'hF;
         end
      end
   end

   assign digitNumber = w_blanked[r_index];
   assign digitSelect = ~(DIGITS'(1) << r_index);
   assign overflow    = r_overflow;

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Scoreboard bench for seven_segment_scan_controller: expected displays are queued at
// accept time and compared when the controller returns to idle and scans the result.
module tb_seven_segment_scan_controller;

   // 14 bits is the narrowest width that carries both 9999 and the first overflowing value 10000.
   localparam int DIGITS   = 4;
   localparam int WIDTH    = 14;
   localparam int SCAN_DIV = 4;
   localparam int SCAN_PERIOD = DIGITS * SCAN_DIV;

   typedef struct {
      int unsigned value;
      logic [15:0] nibbles;
      logic        ovf;
   } expect_t;

   logic              clock = 1'b0;
   logic              resetN;
   logic [3:0]        digitNumber;
   logic [DIGITS-1:0] digitSelect;
   logic              overflow;

   int totalCount = 0;
   int badCount   = 0;
   expect_t sbQueue[$];
   expect_t popped;
   int modelPrescale;
   int modelIndex;

   seven_segment_scan_controller_if #(.WIDTH(WIDTH)) loadBus ();

   seven_segment_scan_controller #(
      .DIGITS   (DIGITS),
      .WIDTH    (WIDTH),
      .SCAN_DIV (SCAN_DIV)
   ) dut (
      .clock       (clock),
      .resetN      (resetN),
      .loadBus     (loadBus),
      .digitNumber (digitNumber),
      .digitSelect (digitSelect),
      .overflow    (overflow)
   );

   always #5 clock = ~clock;

   // Reference scan position, restarted by the same asynchronous reset as the display.
   always @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         modelPrescale <= 0;
         modelIndex    <= 0;
      end else if (modelPrescale == SCAN_DIV - 1) begin
         modelPrescale <= 0;
         modelIndex    <= (modelIndex == DIGITS - 1) ? 0 : modelIndex + 1;
      end else begin
         modelPrescale <= modelPrescale + 1;
      end
   end

   function automatic expect_t modelResult(int unsigned v);
      expect_t     e;
      int          significant;
      int unsigned divisor;
      e.value = v;
      if (v > 9999) begin
         e.ovf     = 1'b1;
         e.nibbles = 16'hFFFF;
      end else begin
         e.ovf = 1'b0;
         significant = (v >= 1000) ? 4 : (v >= 100) ? 3 : (v >= 10) ? 2 : 1;
         divisor = 1;
         for (int i = 0; i < 4; i++) begin
            e.nibbles[4*i +: 4] = (i < significant) ? 4'((v / divisor) % 10) : 4'hF;
            divisor = divisor * 10;
         end
      end
      return e;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      totalCount++;
      if (observed !== expected) begin
         badCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkScan(input string tag, input logic [15:0] nibbles, input int cycles);
      logic [3:0] expSel;
      for (int c = 0; c < cycles; c++) begin
         tick();
         expSel = ~(4'b0001 << modelIndex);
         checkOutput({tag, "_sel"}, 32'(digitSelect), 32'(expSel));
         checkOutput({tag, "_num"}, 32'(digitNumber), 32'(nibbles[4*modelIndex +: 4]));
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_ready"}, 32'(loadBus.loadReady), 32'd1);
      checkOutput({tag, "_ovf"},   32'(overflow),          32'd0);
      checkOutput({tag, "_sel"},   32'(digitSelect),       32'hE);
      checkOutput({tag, "_num"},   32'(digitNumber),       32'h0);
   endtask

   // Waits for the idle state, then presents the value for exactly the accept edge.
   task automatic applyStimulus(input int unsigned v);
      int waited = 0;
      while (loadBus.loadReady !== 1'b1 && waited < 100) begin
         tick();
         waited++;
      end
      if (waited >= 100) begin
         checkOutput("ready_timeout", 32'(loadBus.loadReady), 32'd1);
      end
      loadBus.loadValid = 1'b1;
      loadBus.value     = WIDTH'(v);
      sbQueue.push_back(modelResult(v));
      tick();
      loadBus.loadValid = 1'b0;
   endtask

   task automatic popExpected(input string tag);
      if (sbQueue.size() == 0) begin
         checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
         popped.value   = 0;
         popped.nibbles = 16'hFFF0;
         popped.ovf     = 1'b0;
      end else begin
         popped = sbQueue.pop_front();
      end
   endtask

   // Counts samples with loadReady low, then checks the committed result through the scan.
   task automatic waitCommit(input string tag, input int expectedBusy, input bit doScan);
      int busy = 0;
      while (loadBus.loadReady !== 1'b1 && busy < 200) begin
         busy++;
         tick();
      end
      checkOutput({tag, "_busy"}, 32'(busy), 32'(expectedBusy));
      popExpected(tag);
      checkOutput({tag, "_ovf"}, 32'(overflow), 32'(popped.ovf));
      if (doScan) begin
         checkScan(tag, popped.nibbles, SCAN_PERIOD);
      end
   endtask

   initial begin
      int edges;
      expect_t first;
      resetN            = 1'b1;
      loadBus.loadValid = 1'b0;
      loadBus.value     = '0;

      repeat (2) @(posedge clock);
      #3 resetN = 1'b0;
      #1 checkResetValues("reset_async");
      repeat (2) @(posedge clock);
      @(negedge clock);
      resetN = 1'b1;
      checkResetValues("reset_release");
      checkScan("reset_scan", 16'hFFF0, SCAN_PERIOD + SCAN_DIV);

      applyStimulus(1234);  waitCommit("load1234",  WIDTH + 1, 1'b1);
      applyStimulus(7);     waitCommit("load7",     WIDTH + 1, 1'b1);
      applyStimulus(0);     waitCommit("load0",     WIDTH + 1, 1'b1);
      applyStimulus(1005);  waitCommit("load1005",  WIDTH + 1, 1'b1);
      applyStimulus(10000); waitCommit("load10000", WIDTH + 1, 1'b1);
      applyStimulus(9999);  waitCommit("load9999",  WIDTH + 1, 1'b1);

      // Busy handshake: 8888 is held valid from the cycle after 42 is accepted.
      applyStimulus(42);
      loadBus.loadValid = 1'b1;
      loadBus.value     = WIDTH'(8888);
      edges = 1;
      while (loadBus.loadReady !== 1'b1 && edges < 200) begin
         tick();
         edges++;
      end
      popExpected("busy42");
      first = popped;
      checkOutput("busy42_ovf", 32'(overflow), 32'(first.ovf));
      sbQueue.push_back(modelResult(8888));
      tick();
      loadBus.loadValid = 1'b0;
      checkOutput("busy_accept_edge", 32'(edges), 32'(WIDTH + 2));
      checkOutput("busy_accepted", 32'(loadBus.loadReady), 32'd0);
      checkScan("busy42", first.nibbles, WIDTH);
      waitCommit("load8888", 1, 1'b1);

      // Abort a conversion of 1234 after six iterations.
      applyStimulus(1234);
      repeat (6) tick();
      #2 resetN = 1'b0;
      sbQueue.delete();
      #1 checkResetValues("abort");
      @(negedge clock);
      resetN = 1'b1;
      checkScan("abort_scan", 16'hFFF0, 2 * SCAN_PERIOD);
      checkOutput("abort_ready", 32'(loadBus.loadReady), 32'd1);
      checkOutput("abort_sb", 32'(sbQueue.size()), 32'd0);

      // Valid already high when reset releases: first edge is a normal accept.
      @(negedge clock);
      resetN            = 1'b0;
      loadBus.loadValid = 1'b1;
      loadBus.value     = WIDTH'(7);
      @(negedge clock);
      @(negedge clock);
      resetN = 1'b1;
      sbQueue.push_back(modelResult(7));
      tick();
      loadBus.loadValid = 1'b0;
      checkOutput("release_accept", 32'(loadBus.loadReady), 32'd0);
      waitCommit("release7", WIDTH + 1, 1'b1);

      $display("test done: total=%0d bad=%0d", totalCount, badCount);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
